// File: rtl/mem_access_ctrl.sv
// Single-port memory access sequencer: IDLE -> ACCESS (WAIT_CYCLES cycles) -> DONE.
// Define MEM_ACCESS_ALIGN_CHECK_EN to trap misaligned half/word requests with err_o.
module mem_access_ctrl #(
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  // CPU side
  input  logic        req_i,
  input  logic        we_i,
  input  logic [1:0]  size_i,
  input  logic        sign_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [31:0] rdata_o,
  output logic        err_o,
  // memory side
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic        mem_write_o,
  output logic [3:0]  mem_be_o,
  output logic        mem_sign_o,
  input  logic [31:0] mem_rdata_i
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES - 1);

  state_t      state;
  logic [3:0]  cnt;
  logic        we_q;
  logic        sign_q;
  logic [1:0]  size_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic        misaligned;

  // Size 2'b11 falls into the word case everywhere below.
  function automatic logic [3:0] lane_mask(input logic [1:0] sz, input logic [1:0] a);
    case (sz)
      2'b00:   return 4'b0001 << a;
      2'b01:   return a[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

`ifdef MEM_ACCESS_ALIGN_CHECK_EN
  logic err_q;

  assign misaligned = ((size_i == 2'b01) && addr_i[0]) ||
                      (size_i[1] && (addr_i[1:0] != 2'b00));
  assign err_o      = (state == DONE) && err_q;
`else
  // Misaligned halves/words are truncated by lane_mask and proceed normally.
  assign misaligned = 1'b0;
  assign err_o      = 1'b0;
`endif

  // NOTE: async reset appears in the sensitivity list; state uses non-blocking (<=) so all
  // registers update together from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      we_q    <= 1'b0;
      sign_q  <= 1'b0;
      size_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_o <= '0;
`ifdef MEM_ACCESS_ALIGN_CHECK_EN
      err_q   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (req_i) begin
            we_q    <= we_i;
            sign_q  <= sign_i;
            size_q  <= size_i;
            addr_q  <= addr_i;
            wdata_q <= wdata_i;
            cnt     <= CNT_INIT;
`ifdef MEM_ACCESS_ALIGN_CHECK_EN
            err_q   <= misaligned;
`endif
            if (misaligned) begin
              state   <= DONE;
              rdata_o <= '0;
            end else begin
              state <= ACCESS;
            end
          end
        end
        ACCESS: begin
          if (cnt == 4'd0) begin
            state <= DONE;
            if (!we_q) rdata_o <= mem_rdata_i;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign busy_o      = (state != IDLE);
  assign done_o      = (state == DONE);
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign mem_be_o    = (state == ACCESS) ? lane_mask(size_q, addr_q[1:0]) : 4'b0000;
  assign mem_sign_o  = (state == ACCESS) && sign_q;
  // Single strobe per store: only the last ACCESS cycle writes.
  assign mem_write_o = (state == ACCESS) && we_q && (cnt == 4'd0);

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: WAIT_CYCLES=1 and WAIT_CYCLES=3 instances, each with its own memory.
// Expectations follow MEM_ACCESS_ALIGN_CHECK_EN when defined at compile time.
module tb_mem_access_ctrl;

`ifdef MEM_ACCESS_ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        req       [2];
  logic        we        [2];
  logic [1:0]  size      [2];
  logic        sign      [2];
  logic [31:0] addr      [2];
  logic [31:0] wdata     [2];
  logic        busy      [2];
  logic        done      [2];
  logic [31:0] rdata     [2];
  logic        err       [2];
  logic [31:0] mem_addr  [2];
  logic [31:0] mem_wdata [2];
  logic        mem_write [2];
  logic [3:0]  mem_be    [2];
  logic        mem_sign  [2];
  logic [31:0] mem_rdata [2];

  logic [31:0] mem [2][16] = '{default: '0};

  int n_cmp = 0;
  int n_bad = 0;

  mem_access_ctrl #(.WAIT_CYCLES(1)) u_dut1 (
    .clk(clk), .rst(rst),
    .req_i(req[0]), .we_i(we[0]), .size_i(size[0]), .sign_i(sign[0]),
    .addr_i(addr[0]), .wdata_i(wdata[0]),
    .busy_o(busy[0]), .done_o(done[0]), .rdata_o(rdata[0]), .err_o(err[0]),
    .mem_addr_o(mem_addr[0]), .mem_wdata_o(mem_wdata[0]), .mem_write_o(mem_write[0]),
    .mem_be_o(mem_be[0]), .mem_sign_o(mem_sign[0]), .mem_rdata_i(mem_rdata[0])
  );

  mem_access_ctrl #(.WAIT_CYCLES(3)) u_dut3 (
    .clk(clk), .rst(rst),
    .req_i(req[1]), .we_i(we[1]), .size_i(size[1]), .sign_i(sign[1]),
    .addr_i(addr[1]), .wdata_i(wdata[1]),
    .busy_o(busy[1]), .done_o(done[1]), .rdata_o(rdata[1]), .err_o(err[1]),
    .mem_addr_o(mem_addr[1]), .mem_wdata_o(mem_wdata[1]), .mem_write_o(mem_write[1]),
    .mem_be_o(mem_be[1]), .mem_sign_o(mem_sign[1]), .mem_rdata_i(mem_rdata[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory stub: lanes picked by byte enables, store data taken right-justified.
  function automatic logic [31:0] wr_merge(input logic [31:0] w, input logic [3:0] be,
                                           input logic [31:0] d);
    logic [31:0] r;
    r = w;
    case (be)
      4'b0001: r[7:0]   = d[7:0];
      4'b0010: r[15:8]  = d[7:0];
      4'b0100: r[23:16] = d[7:0];
      4'b1000: r[31:24] = d[7:0];
      4'b0011: r[15:0]  = d[15:0];
      4'b1100: r[31:16] = d[15:0];
      4'b1111: r        = d;
      default: r        = w;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] rd_ext(input logic [31:0] w, input logic [3:0] be,
                                         input logic s);
    case (be)
      4'b0001: return {{24{s & w[7]}},  w[7:0]};
      4'b0010: return {{24{s & w[15]}}, w[15:8]};
      4'b0100: return {{24{s & w[23]}}, w[23:16]};
      4'b1000: return {{24{s & w[31]}}, w[31:24]};
      4'b0011: return {{16{s & w[15]}}, w[15:0]};
      4'b1100: return {{16{s & w[31]}}, w[31:16]};
      4'b1111: return w;
      default: return 32'h0;
    endcase
  endfunction

  always @(posedge clk)
    for (int i = 0; i < 2; i++)
      if (mem_write[i])
        mem[i][mem_addr[i][5:2]] <= wr_merge(mem[i][mem_addr[i][5:2]], mem_be[i], mem_wdata[i]);

  assign mem_rdata[0] = rd_ext(mem[0][mem_addr[0][5:2]], mem_be[0], mem_sign[0]);
  assign mem_rdata[1] = rd_ext(mem[1][mem_addr[1][5:2]], mem_be[1], mem_sign[1]);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Results of the last run_xfer call.
  int          m_lat, m_hit, m_nz, m_wr, m_sbad;
  logic        m_err, m_idle;
  logic [31:0] m_rd, m_wraddr;

  // One transfer on instance i; optionally holds req_i high from the 2nd cycle after acceptance.
  task automatic run_xfer(input int i, input logic w, input logic [1:0] sz, input logic s,
                          input logic [31:0] a, input logic [31:0] wd, input bit poke,
                          input logic [3:0] ebe);
    @(negedge clk);
    we[i] = w; size[i] = sz; sign[i] = s; addr[i] = a; wdata[i] = wd; req[i] = 1'b1;
    @(posedge clk);
    #1 req[i] = 1'b0;
    m_lat = 0; m_hit = 0; m_nz = 0; m_wr = 0; m_sbad = 0;
    m_err = 1'bx; m_rd = 'x; m_wraddr = 'x;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      req[i] = poke && (k >= 2);
      if (mem_be[i] != 4'b0000) m_nz++;
      if (mem_be[i] == ebe) m_hit++;
      if (mem_write[i]) begin
        m_wr++;
        m_wraddr = mem_addr[i];
      end
      if (mem_sign[i] !== ((busy[i] && !done[i]) ? s : 1'b0)) m_sbad++;
      if (done[i]) begin
        m_lat = k;
        m_err = err[i];
        m_rd  = rdata[i];
        break;
      end
    end
    @(posedge clk);
    #1 req[i] = 1'b0;
    m_idle = !busy[i] && !done[i];
  endtask

  typedef struct {
    int          inst;
    logic        we;
    logic [1:0]  size;
    logic        sign;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    bit          trap;
    logic [31:0] rdata;
    string       name;
  } vec_t;

  function automatic vec_t mk(input int inst, input logic w, input logic [1:0] sz,
                              input logic s, input logic [31:0] a, input logic [31:0] wd,
                              input logic [3:0] be, input bit trap, input logic [31:0] rd,
                              input string nm);
    vec_t v;
    v.inst = inst; v.we = w; v.size = sz; v.sign = s; v.addr = a; v.wdata = wd;
    v.be = be; v.trap = trap; v.rdata = rd; v.name = nm;
    return v;
  endfunction

  vec_t vecs[$];

  initial begin
    int wcyc;
    int ev;
    vec_t v;

    // Memory contents evolve in table order; rdata of a store is the previous load result.
    vecs.push_back(mk(0, 1, 2'b10, 0, 32'h10, 32'hDEADBEEF, 4'b1111, 0, 32'h0, "st_w_10"));
    vecs.push_back(mk(0, 1, 2'b00, 0, 32'h13, 32'h000000A5, 4'b1000, 0, 32'h0, "st_b_13"));
    vecs.push_back(mk(0, 0, 2'b00, 1, 32'h13, 32'h0, 4'b1000, 0, 32'hFFFFFFA5, "ld_b_13s"));
    vecs.push_back(mk(0, 0, 2'b00, 0, 32'h13, 32'h0, 4'b1000, 0, 32'h000000A5, "ld_b_13u"));
    vecs.push_back(mk(0, 0, 2'b01, 1, 32'h12, 32'h0, 4'b1100, 0, 32'hFFFFA5AD, "ld_h_12s"));
    vecs.push_back(mk(0, 0, 2'b10, 0, 32'h11, 32'h0, 4'b1111, ALIGN,
                      ALIGN ? 32'h0 : 32'hA5ADBEEF, "ld_w_11"));
    vecs.push_back(mk(0, 0, 2'b00, 1, 32'h10, 32'h0, 4'b0001, 0, 32'hFFFFFFEF, "ld_b_10s"));
    vecs.push_back(mk(0, 0, 2'b01, 0, 32'h13, 32'h0, 4'b1100, ALIGN,
                      ALIGN ? 32'h0 : 32'h0000A5AD, "ld_h_13"));
    vecs.push_back(mk(0, 0, 2'b00, 0, 32'h11, 32'h0, 4'b0010, 0, 32'h000000BE, "ld_b_11u"));
    vecs.push_back(mk(0, 1, 2'b01, 0, 32'h14, 32'hCAFE1234, 4'b0011, 0, 32'h000000BE, "st_h_14"));
    vecs.push_back(mk(0, 1, 2'b01, 0, 32'h16, 32'h00008899, 4'b1100, 0, 32'h000000BE, "st_h_16"));
    vecs.push_back(mk(0, 0, 2'b10, 0, 32'h14, 32'h0, 4'b1111, 0, 32'h88991234, "ld_w_14"));
    vecs.push_back(mk(0, 0, 2'b11, 0, 32'h10, 32'h0, 4'b1111, 0, 32'hA5ADBEEF, "ld_x_10"));
    vecs.push_back(mk(0, 0, 2'b01, 1, 32'h16, 32'h0, 4'b1100, 0, 32'hFFFF8899, "ld_h_16s"));
    vecs.push_back(mk(0, 1, 2'b00, 0, 32'h12, 32'hFFFFFF77, 4'b0100, 0, 32'hFFFF8899, "st_b_12"));
    vecs.push_back(mk(0, 0, 2'b10, 0, 32'h10, 32'h0, 4'b1111, 0, 32'hA577BEEF, "ld_w_10"));
    vecs.push_back(mk(1, 1, 2'b10, 0, 32'h10, 32'hDEADBEEF, 4'b1111, 0, 32'h0, "w3_st_w_10"));
    vecs.push_back(mk(1, 1, 2'b00, 0, 32'h13, 32'h000000A5, 4'b1000, 0, 32'h0, "w3_st_b_13"));

    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      req[i] = 0; we[i] = 0; size[i] = 0; sign[i] = 0; addr[i] = 0; wdata[i] = 0;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("rst_ctl%0d", i),
            {busy[i], done[i], err[i], mem_write[i], mem_sign[i], mem_be[i]}, 32'h0);
      check($sformatf("rst_rdata%0d", i), rdata[i], 32'h0);
      check($sformatf("rst_addr%0d", i), mem_addr[i], 32'h0);
      check($sformatf("rst_wdata%0d", i), mem_wdata[i], 32'h0);
    end
    rst = 1'b0;

    foreach (vecs[n]) begin
      v = vecs[n];
      wcyc = (v.inst == 1) ? 3 : 1;
      run_xfer(v.inst, v.we, v.size, v.sign, v.addr, v.wdata, 1'b0, v.be);
      check({v.name, ":lat"},   m_lat,  v.trap ? 1 : wcyc + 1);
      check({v.name, ":be"},    m_hit,  v.trap ? 0 : wcyc);
      check({v.name, ":be_nz"}, m_nz,   v.trap ? 0 : wcyc);
      check({v.name, ":wr"},    m_wr,   (v.we && !v.trap) ? 1 : 0);
      if (v.we && !v.trap) check({v.name, ":wr_addr"}, m_wraddr, v.addr);
      check({v.name, ":err"},   m_err,  v.trap);
      check({v.name, ":rdata"}, m_rd,   v.rdata);
      check({v.name, ":sign"},  m_sbad, 0);
      check({v.name, ":idle"},  m_idle, 1);
    end
    check("mem0_w4", mem[0][4], 32'hA577BEEF);

    // WAIT_CYCLES=3 half load with req_i held high through ACCESS and DONE.
    run_xfer(1, 1'b0, 2'b01, 1'b0, 32'h12, 32'h0, 1'b1, 4'b1100);
    check("poke:lat",   m_lat,  4);
    check("poke:be",    m_hit,  3);
    check("poke:be_nz", m_nz,   3);
    check("poke:rdata", m_rd,   32'h0000A5AD);
    check("poke:idle",  m_idle, 1);

    // Reset in the 2nd ACCESS cycle of a store aborts it without a write or done pulse.
    @(negedge clk);
    we[1] = 1; size[1] = 2'b10; sign[1] = 0; addr[1] = 32'h10; wdata[1] = 32'h11111111;
    req[1] = 1;
    @(posedge clk);
    #1 req[1] = 0;
    @(negedge clk);
    check("abort:busy1", busy[1], 1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort:ctl",   {busy[1], done[1], err[1], mem_write[1], mem_sign[1], mem_be[1]}, 32'h0);
    check("abort:rdata", rdata[1], 32'h0);
    check("abort:addr",  mem_addr[1], 32'h0);
    check("abort:wdata", mem_wdata[1], 32'h0);
    ev = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (k == 1) rst = 1'b0;
      if (mem_write[1] || done[1] || busy[1]) ev++;
    end
    check("abort:quiet", ev, 0);
    check("abort:mem",   mem[1][4], 32'hA5ADBEEF);

    run_xfer(1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b0, 4'b1111);
    check("post_rst:lat",   m_lat, 4);
    check("post_rst:rdata", m_rd,  32'hA5ADBEEF);
    check("post_rst:err",   m_err, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1);
  end

endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 The block SHALL have parameter WAIT_CYCLES, default 1, setting the number of ACCESS-state cycles per transfer (legal range 1..15).
REQ-002 The block SHALL have port clk, input, 1, system clock, rising-edge active.
REQ-003 The block SHALL have port rst, input, 1, reset, asynchronous, active-high.
REQ-004 The block SHALL have the following CPU-side ports:
- req_i, input, 1: request strobe, sampled only in IDLE.
- we_i, input, 1: 1 = store, 0 = load.
- size_i, input, 2: 00 byte, 01 half, 10 word; 11 is treated as word.
- sign_i, input, 1: sign-extend the load result.
- addr_i, input, 32: byte address.
- wdata_i, input, 32: store data, right-justified.
- busy_o, output, 1: high whenever the state is not IDLE.
- done_o, output, 1: one-cycle completion pulse.
- rdata_o, output, 32: load result, held until the next done_o.
- err_o, output, 1: misalignment flag, valid while done_o is high.
REQ-005 The block SHALL have the following memory-side ports:
- mem_addr_o, output, 32: byte address.
- mem_wdata_o, output, 32: store data.
- mem_write_o, output, 1: write strobe.
- mem_be_o, output, 4: byte-lane enables.
- mem_sign_o, output, 1: extension select.
- mem_rdata_i, input, 32: already-extended combinational read data.

Function
REQ-006 The FSM SHALL have states IDLE, ACCESS and DONE.
REQ-007 In IDLE, req_i=1 at a rising edge SHALL latch we_i, size_i, sign_i, addr_i and wdata_i, load the wait counter with WAIT_CYCLES-1, and enter ACCESS.
REQ-008 req_i SHALL be ignored in ACCESS and DONE; there is no queuing.
REQ-009 In ACCESS, the counter SHALL decrement each cycle; at count 0 the next state SHALL be DONE.
REQ-010 DONE SHALL last exactly one cycle, with done_o=1, and SHALL then return to IDLE.
REQ-011 Latency: req_i sampled at edge t0 SHALL give ACCESS for cycles t0+1..t0+WAIT_CYCLES and done_o=1 in cycle t0+WAIT_CYCLES+1.
REQ-012 mem_be_o SHALL be derived from the latched size and addr[1:0]:
- byte: 4'b0001 shifted left by addr[1:0].
- half: 4'b1100 if addr[1]=1, else 4'b0011.
- word: 4'b1111.
REQ-013 mem_be_o SHALL be 0 outside ACCESS.
REQ-014 mem_addr_o SHALL equal the latched address; mem_wdata_o SHALL equal the latched wdata, unshifted (the memory selects lanes from the low bits).
REQ-015 mem_sign_o SHALL equal the latched sign during ACCESS and be 0 otherwise.
REQ-016 mem_write_o SHALL be 1 only in the final ACCESS cycle (count 0) of a store: exactly one write strobe per store.
REQ-017 For a load, rdata_o SHALL register mem_rdata_i on the edge that leaves ACCESS.
REQ-018 For a store, rdata_o SHALL be unchanged.
REQ-019 busy_o SHALL be the combinational decode of state != IDLE.

Reset
REQ-020 rst=1 SHALL force IDLE and clear all latched fields and the counter.
REQ-021 rst=1 SHALL drive done_o, err_o, busy_o, mem_write_o, mem_sign_o, mem_be_o, mem_addr_o, mem_wdata_o and rdata_o to 0.
REQ-022 rst asserted during ACCESS SHALL abort the transfer with no write strobe after the reset edge and no done_o pulse.
REQ-023 The first request after reset deassertion SHALL be accepted normally.

Configuration
REQ-024 With macro MEM_ACCESS_ALIGN_CHECK_EN defined, misaligned requests SHALL be trapped:
- misaligned = half with addr[0]=1, or word with addr[1:0]!=0.
- the request goes IDLE->DONE directly, skipping ACCESS.
- mem_write_o stays 0 and mem_be_o stays 0.
- err_o=1 with done_o, and rdata_o is cleared to 0.
REQ-025 Without MEM_ACCESS_ALIGN_CHECK_EN, err_o SHALL be tied 0 and misaligned addresses SHALL be truncated:
- a half uses addr[1] only.
- a word uses 4'b1111.
- the access proceeds normally.

Verification
REQ-026 WAIT_CYCLES=1, store word addr 0x10, wdata 0xDEADBEEF -> one mem_write_o cycle with be=1111 and addr=0x10; done_o two cycles after the req edge; the memory word holds 0xDEADBEEF.
REQ-027 Store byte addr 0x13, wdata 0x000000A5 -> be=1000 and the memory word becomes 0xA5ADBEEF; a following load byte with sign=1 from addr 0x13 -> rdata_o=0xFFFFFFA5; with sign=0 -> 0x000000A5.
REQ-028 WAIT_CYCLES=3, load half addr 0x12 with sign=0 -> be=1100 held for 3 cycles, done_o in cycle t0+4, rdata_o=0x0000A5AD; req_i pulsed during ACCESS is ignored.
REQ-029 Macro defined, load word addr 0x11 -> done_o and err_o in cycle t0+1, no mem_be_o activity, rdata_o=0; macro undefined, the same request -> err_o=0 and rdata_o=0xA5ADBEEF.
REQ-030 WAIT_CYCLES=3, store word with rst pulsed in the 2nd ACCESS cycle -> mem_write_o never asserted, no done_o, memory unchanged, all outputs 0; the next request completes normally.
